// File: rtl/regbank_pkg.sv
// Shared definitions for the double-buffered LED-controller register bank:
// register map, CTRL/STATUS bit positions and the commit FSM state type.
package regbank_pkg;

    localparam logic [3:0] RTL_REVISION_MAJOR = 4'd2;
    localparam logic [3:0] RTL_REVISION_MINOR = 4'd0;

    localparam int unsigned ADDR_ZERO     = 0;
    localparam int unsigned ADDR_REV      = 1;
    localparam int unsigned ADDR_T0H      = 2;
    localparam int unsigned ADDR_T0L      = 3;
    localparam int unsigned ADDR_T1H      = 4;
    localparam int unsigned ADDR_T1L      = 5;
    localparam int unsigned ADDR_CHAN_LEN = 6;
    localparam int unsigned ADDR_CHAN_CNT = 7;
    localparam int unsigned ADDR_CTRL     = 8;
    localparam int unsigned ADDR_STATUS   = 9;

    localparam int unsigned CTRL_APPLY_BIT     = 0;
    localparam int unsigned CTRL_CLR_ERR_BIT   = 1;
    localparam int unsigned STATUS_PENDING_BIT = 0;
    localparam int unsigned STATUS_CLAMP_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } commit_state_e;

    function automatic logic is_field_addr(input int unsigned addr);
        return (addr >= ADDR_T0H) && (addr <= ADDR_CHAN_CNT);
    endfunction

endpackage

// File: rtl/regbank_commit_fsm.sv
// Apply/commit sequencer: holds an apply request until the waveform generator
// is between frames, then issues a single-cycle commit.
module regbank_commit_fsm
    import regbank_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic apply_i,
    input  logic frame_idle_i,
    output logic pending_o,
    output logic commit_o
);

    commit_state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Apply outside IDLE is deliberately ignored so commits never queue up.
    always_comb begin
        state_d   = state_q;
        commit_o  = 1'b0;
        pending_o = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (apply_i) state_d = PENDING;
            end
            PENDING: begin
                if (frame_idle_i) state_d = COMMIT;
            end
            COMMIT: begin
                commit_o = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/regbank_dbuf.sv
// Double-buffered register bank: shadow registers written by the host, active
// registers loaded on commit. Define REGBANK_AUTO_APPLY_EN to make field writes apply.
module regbank_dbuf
    import regbank_pkg::*;
#(
    parameter int unsigned TIME_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned NUM_CHAN   = 8,
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr_i,
    input  logic                  reg_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] reg_wr_addr_i,
    input  logic [7:0]            reg_wr_data_i,
    input  logic                  frame_idle_i,
    output logic [7:0]            reg_rd_data_o,
    output logic [TIME_WIDTH-1:0] reg_t0h_time_o,
    output logic [TIME_WIDTH:0]   reg_t0s_time_o,
    output logic [TIME_WIDTH-1:0] reg_t1h_time_o,
    output logic [TIME_WIDTH:0]   reg_t1s_time_o,
    output logic [LEN_WIDTH-1:0]  reg_chan_len_o,
    output logic [CNT_WIDTH-1:0]  reg_chan_cnt_o,
    output logic                  commit_o
);

    logic [31:0] wr_addr, rd_addr;
    logic        ctrl_wr, apply, pending, commit;

    logic [TIME_WIDTH-1:0] sh_t0h_q, sh_t0h_d, sh_t0l_q, sh_t0l_d;
    logic [TIME_WIDTH-1:0] sh_t1h_q, sh_t1h_d, sh_t1l_q, sh_t1l_d;
    logic [LEN_WIDTH-1:0]  sh_len_q, sh_len_d;
    logic [CNT_WIDTH-1:0]  sh_cnt_q, sh_cnt_d;
    logic                  clamp_err_q, clamp_err_d;

    logic [TIME_WIDTH-1:0] act_t0h_q, act_t0l_q, act_t1h_q, act_t1l_q;
    logic [LEN_WIDTH-1:0]  act_len_q;
    logic [CNT_WIDTH-1:0]  act_cnt_q;

    assign wr_addr = 32'(reg_wr_addr_i);
    assign rd_addr = 32'(reg_rd_addr_i);
    assign ctrl_wr = reg_wr_en_i && (wr_addr == ADDR_CTRL);

`ifdef REGBANK_AUTO_APPLY_EN
    assign apply = (ctrl_wr && reg_wr_data_i[CTRL_APPLY_BIT])
                || (reg_wr_en_i && is_field_addr(wr_addr));
`else
    assign apply = ctrl_wr && reg_wr_data_i[CTRL_APPLY_BIT];
`endif

    regbank_commit_fsm u_commit_fsm (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .apply_i      (apply),
        .frame_idle_i (frame_idle_i),
        .pending_o    (pending),
        .commit_o     (commit)
    );

    // Clear is evaluated before set so a clamping write always leaves the error flagged.
    always_comb begin
        sh_t0h_d    = sh_t0h_q;
        sh_t0l_d    = sh_t0l_q;
        sh_t1h_d    = sh_t1h_q;
        sh_t1l_d    = sh_t1l_q;
        sh_len_d    = sh_len_q;
        sh_cnt_d    = sh_cnt_q;
        clamp_err_d = clamp_err_q;
        if (ctrl_wr && reg_wr_data_i[CTRL_CLR_ERR_BIT]) clamp_err_d = 1'b0;
        if (reg_wr_en_i) begin
            unique case (wr_addr)
                ADDR_T0H:      sh_t0h_d = reg_wr_data_i[TIME_WIDTH-1:0];
                ADDR_T0L:      sh_t0l_d = reg_wr_data_i[TIME_WIDTH-1:0];
                ADDR_T1H:      sh_t1h_d = reg_wr_data_i[TIME_WIDTH-1:0];
                ADDR_T1L:      sh_t1l_d = reg_wr_data_i[TIME_WIDTH-1:0];
                ADDR_CHAN_LEN: sh_len_d = reg_wr_data_i[LEN_WIDTH-1:0];
                ADDR_CHAN_CNT: begin
                    if (32'(reg_wr_data_i) > NUM_CHAN) begin
                        sh_cnt_d    = CNT_WIDTH'(NUM_CHAN);
                        clamp_err_d = 1'b1;
                    end else begin
                        sh_cnt_d = reg_wr_data_i[CNT_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_t0h_q    <= '0;
            sh_t0l_q    <= '0;
            sh_t1h_q    <= '0;
            sh_t1l_q    <= '0;
            sh_len_q    <= '0;
            sh_cnt_q    <= '0;
            clamp_err_q <= 1'b0;
        end else begin
            sh_t0h_q    <= sh_t0h_d;
            sh_t0l_q    <= sh_t0l_d;
            sh_t1h_q    <= sh_t1h_d;
            sh_t1l_q    <= sh_t1l_d;
            sh_len_q    <= sh_len_d;
            sh_cnt_q    <= sh_cnt_d;
            clamp_err_q <= clamp_err_d;
        end
    end

    // Copy reads the registered shadow, so a write landing in the commit cycle is not taken.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_t0h_q <= '0;
            act_t0l_q <= '0;
            act_t1h_q <= '0;
            act_t1l_q <= '0;
            act_len_q <= '0;
            act_cnt_q <= '0;
        end else if (commit) begin
            act_t0h_q <= sh_t0h_q;
            act_t0l_q <= sh_t0l_q;
            act_t1h_q <= sh_t1h_q;
            act_t1l_q <= sh_t1l_q;
            act_len_q <= sh_len_q;
            act_cnt_q <= sh_cnt_q;
        end
    end

    always_comb begin
        reg_rd_data_o = '0;
        unique case (rd_addr)
            ADDR_REV:      reg_rd_data_o = {RTL_REVISION_MAJOR, RTL_REVISION_MINOR};
            ADDR_T0H:      reg_rd_data_o = 8'(sh_t0h_q);
            ADDR_T0L:      reg_rd_data_o = 8'(sh_t0l_q);
            ADDR_T1H:      reg_rd_data_o = 8'(sh_t1h_q);
            ADDR_T1L:      reg_rd_data_o = 8'(sh_t1l_q);
            ADDR_CHAN_LEN: reg_rd_data_o = 8'(sh_len_q);
            ADDR_CHAN_CNT: reg_rd_data_o = 8'(sh_cnt_q);
            ADDR_STATUS: begin
                reg_rd_data_o[STATUS_PENDING_BIT] = pending;
                reg_rd_data_o[STATUS_CLAMP_BIT]   = clamp_err_q;
            end
            default: ;
        endcase
    end

    assign reg_t0h_time_o = act_t0h_q;
    assign reg_t1h_time_o = act_t1h_q;
    assign reg_t0s_time_o = {1'b0, act_t0h_q} + {1'b0, act_t0l_q};
    assign reg_t1s_time_o = {1'b0, act_t1h_q} + {1'b0, act_t1l_q};
    assign reg_chan_len_o = act_len_q;
    assign reg_chan_cnt_o = act_cnt_q;
    assign commit_o       = commit;

endmodule

// File: tb/tb_regbank_dbuf.sv
// Self-checking bench for regbank_dbuf: directed scenarios plus random traffic
// compared every cycle against a register-level reference model.
module tb_regbank_dbuf;

    localparam int unsigned NCH = 8;
    localparam int unsigned REV = 'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rd_addr = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       frame_idle = 1'b0;
    logic [7:0] rd_data;
    logic [7:0] t0h, t1h, chan_len;
    logic [8:0] t0s, t1s;
    logic [3:0] chan_cnt;
    logic       commit;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: shadow/active register arrays indexed by address 2..7
    int unsigned sh[8];
    int unsigned ac[8];
    bit          m_clamp, m_pend, m_comm;
    int unsigned pulses;

    regbank_dbuf #(
        .TIME_WIDTH(8), .LEN_WIDTH(8), .NUM_CHAN(NCH), .CNT_WIDTH(4), .ADDR_WIDTH(4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .reg_rd_addr_i  (rd_addr),
        .reg_wr_en_i    (wr_en),
        .reg_wr_addr_i  (wr_addr),
        .reg_wr_data_i  (wr_data),
        .frame_idle_i   (frame_idle),
        .reg_rd_data_o  (rd_data),
        .reg_t0h_time_o (t0h),
        .reg_t0s_time_o (t0s),
        .reg_t1h_time_o (t1h),
        .reg_t1s_time_o (t1s),
        .reg_chan_len_o (chan_len),
        .reg_chan_cnt_o (chan_cnt),
        .commit_o       (commit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned exp_read(input int unsigned a);
        if (a == 1) return REV;
        if (a >= 2 && a <= 7) return sh[a];
        if (a == 9) return (int'(m_clamp) << 1) | int'(m_pend);
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            sh[i] = 0;
            ac[i] = 0;
        end
        m_clamp = 0;
        m_pend  = 0;
        m_comm  = 0;
    endtask

    task automatic check_outputs(input int unsigned ra);
        check("rd_data", rd_data, exp_read(ra));
        check("commit", commit, m_comm);
        check("t0h", t0h, ac[2]);
        check("t0s", t0s, ac[2] + ac[3]);
        check("t1h", t1h, ac[4]);
        check("t1s", t1s, ac[4] + ac[5]);
        check("chan_len", chan_len, ac[6]);
        check("chan_cnt", chan_cnt, ac[7]);
    endtask

    // One clock: drive at negedge, compare before the edge, advance model at the edge.
    task automatic step(input bit we, input int unsigned wa, input int unsigned wd,
                        input bit idle, input int unsigned ra);
        bit ap;
        @(negedge clk);
        wr_en      = we;
        wr_addr    = 4'(wa);
        wr_data    = 8'(wd);
        frame_idle = idle;
        rd_addr    = 4'(ra);
        #1;
        check_outputs(ra);
        if (commit) pulses++;
        @(posedge clk);
        if (m_comm) for (int i = 2; i < 8; i++) ac[i] = sh[i];
        ap = 0;
        if (we) begin
            if (wa >= 2 && wa <= 6) sh[wa] = wd & 'hFF;
            if (wa == 7) begin
                if (wd > NCH) begin
                    sh[7]   = NCH;
                    m_clamp = 1;
                end else begin
                    sh[7] = wd;
                end
            end
            if (wa == 8) begin
                if (wd & 2) m_clamp = 0;
                if (wd & 1) ap = 1;
            end
`ifdef REGBANK_AUTO_APPLY_EN
            if (wa >= 2 && wa <= 7) ap = 1;
`endif
        end
        if (m_comm) begin
            m_comm = 0;
            m_pend = 0;
        end else if (m_pend) begin
            m_comm = idle;
        end else begin
            m_pend = ap;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        model_reset();
        #2;
        check("rst_commit", commit, 0);
        check("rst_t0s", t0s, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        pulses = 0;
        do_reset();

        // Reset contents of the whole map
        for (int unsigned a = 0; a < 16; a++) step(0, 0, 0, 0, a);

        // Shadow writes without apply leave active untouched; apply waits for idle
        step(1, 2, 'h10, 0, 9);
        step(1, 3, 'h20, 0, 9);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 9);
        step(1, 8, 'h01, 0, 9);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 9);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 9);

        // Maximum timing values and N+2 commit latency
        step(1, 4, 'hFF, 1, 4);
        step(1, 5, 'hFF, 1, 5);
        pulses = 0;
        step(1, 8, 'h01, 1, 9);
        step(0, 0, 0, 1, 9);
        step(0, 0, 0, 1, 9);
        check("latency_pulse", pulses, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 9);

        // CHAN_CNT clamp boundary and sticky error clear
        step(1, 7, 12, 0, 7);
        step(0, 0, 0, 0, 9);
        step(1, 8, 'h02, 0, 9);
        step(1, 7, 8, 0, 9);
        step(1, 7, 9, 0, 7);
        step(1, 8, 'h02, 0, 9);
        step(0, 0, 0, 0, 9);

        // Shadow write in the commit cycle, then a redundant apply while pending
        step(1, 8, 'h01, 1, 6);
        step(0, 0, 0, 1, 6);
        step(1, 6, 'h40, 1, 6);
        step(0, 0, 0, 1, 6);
        step(0, 0, 0, 1, 9);
        pulses = 0;
        step(1, 8, 'h01, 0, 9);
        step(1, 8, 'h01, 0, 9);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 9);
        check("single_commit", pulses, 1);

        // Reset while pending drops the commit
        step(1, 8, 'h01, 0, 9);
        step(0, 0, 0, 0, 9);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 9);
        check("no_commit_after_rst", pulses, 0);

        // Field write with idle high (commits only in auto-apply builds)
        step(1, 2, 'h33, 1, 9);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            int unsigned wa, wd;
            wa = $urandom_range(0, 15);
            wd = (wa == 7) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            if (wa == 8 && $urandom_range(0, 3) == 0) wd = $urandom_range(0, 3);
            if ($urandom_range(0, 299) == 0) do_reset();
            step(bit'($urandom_range(0, 1)), wa, wd,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
